// File: rtl/divider_pkg.sv
// Shared arithmetic-unit definitions: control states and operand width.
package divider_pkg;

   localparam int unsigned OP_WIDTH = 32;

   typedef enum logic [1:0] {
      INIT = 2'b00,
      CAL  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Iteration counter width; one spare bit so the count can reach WIDTH.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/cla32.sv
// Carry-lookahead adder built from 4-bit lookahead groups.
module cla32
   import divider_pkg::*;
#(
   parameter int unsigned W = OP_WIDTH
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         ci_i,
   output logic [W-1:0] sum_c_o,
   output logic         co_c_o
);

   localparam int unsigned GROUPS = W / 4;

   logic [W-1:0] g;
   logic [W-1:0] p;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Intra-group ripple, inter-group lookahead carry.
   always_comb begin
      logic [W:0] c;
      c    = '0;
      c[0] = ci_i;
      for (int k = 0; k < int'(GROUPS); k++) begin
         for (int j = 0; j < 3; j++) begin
            c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
         end
         c[4*k+4] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
      sum_c_o = p ^ c[W-1:0];
      co_c_o  = c[W];
   end

endmodule

// File: rtl/divider_ns.sv
// Next-state logic for the divider control FSM.
module divider_ns
   import divider_pkg::*;
#(
   parameter int unsigned CNT_W = 6,
   parameter int unsigned LAST  = 31
) (
   input  state_e           state_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             op_start_i,
   input  logic             op_clear_i,
   output state_e           state_c_o
);

   // Clear dominates every state; start only leaves INIT.
   always_comb begin
      state_c_o = state_i;
      if (op_clear_i) begin
         state_c_o = INIT;
      end else begin
         case (state_i)
            INIT:    if (op_start_i) state_c_o = CAL;
            CAL:     if (cnt_i == CNT_W'(LAST)) state_c_o = DONE;
            DONE:    state_c_o = DONE;
            default: state_c_o = INIT;
         endcase
      end
   end

endmodule

// File: rtl/divider.sv
// Sequential radix-2 non-restoring divider, {remainder, quotient} after WIDTH cycles.
module divider
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH  = OP_WIDTH,
   parameter bit          SIGNED = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   input  logic                 op_start,
   input  logic                 op_clear,
   output logic                 op_done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 div_by_zero
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);
   localparam int unsigned LAST  = WIDTH - 1;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH:0]       p_q;
   logic [WIDTH-1:0]     q_q;
   logic [WIDTH-1:0]     dvs_q;
   logic [WIDTH-1:0]     dvd_q;
   logic                 neg_quo_q;
   logic                 neg_rem_q;
   logic                 zero_q;
   logic [2*WIDTH-1:0]   result_q;
   logic                 done_q;
   logic                 dbz_q;

   logic                 dvd_neg, dvs_neg;
   logic [WIDTH-1:0]     dvd_abs, dvs_abs;
   logic [WIDTH:0]       shifted, addend, p_step;
   logic [WIDTH-1:0]     step_sum, q_step;
   logic                 step_sub, step_co;
   logic [WIDTH-1:0]     rem_mag, quo_fin, rem_fin;

   divider_ns #(
      .CNT_W (CNT_W),
      .LAST  (LAST)
   ) u_ns (
      .state_i    (state_q),
      .cnt_i      (cnt_q),
      .op_start_i (op_start),
      .op_clear_i (op_clear),
      .state_c_o  (state_d)
   );

   // Operand signs and magnitudes captured on the start edge.
   assign dvd_neg = SIGNED & dividend[WIDTH-1];
   assign dvs_neg = SIGNED & divisor[WIDTH-1];
   assign dvd_abs = dvd_neg ? WIDTH'(-dividend) : dividend;
   assign dvs_abs = dvs_neg ? WIDTH'(-divisor) : divisor;

   // One non-restoring step: subtract when P is non-negative, add otherwise.
   assign shifted  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign step_sub = ~p_q[WIDTH];
   assign addend   = step_sub ? ~{1'b0, dvs_q} : {1'b0, dvs_q};

   cla32 #(
      .W (WIDTH)
   ) u_step (
      .a_i     (shifted[WIDTH-1:0]),
      .b_i     (addend[WIDTH-1:0]),
      .ci_i    (step_sub),
      .sum_c_o (step_sum),
      .co_c_o  (step_co)
   );

   assign p_step = {shifted[WIDTH] ^ addend[WIDTH] ^ step_co, step_sum};
   assign q_step = {q_q[WIDTH-2:0], ~p_step[WIDTH]};

   // Final remainder correction and sign fix-up, with divide-by-zero override.
   always_comb begin
      rem_mag = p_step[WIDTH] ? WIDTH'(p_step[WIDTH-1:0] + dvs_q) : p_step[WIDTH-1:0];
      quo_fin = neg_quo_q ? WIDTH'(-q_step) : q_step;
      rem_fin = neg_rem_q ? WIDTH'(-rem_mag) : rem_mag;
      if (zero_q) begin
         quo_fin = '1;
         rem_fin = dvd_q;
      end
   end

   // Control state, iteration datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= INIT;
         cnt_q     <= '0;
         p_q       <= '0;
         q_q       <= '0;
         dvs_q     <= '0;
         dvd_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
         result_q  <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (op_clear) begin
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
         end else begin
            case (state_q)
               INIT: begin
                  if (op_start) begin
                     neg_quo_q <= dvd_neg ^ dvs_neg;
                     neg_rem_q <= dvd_neg;
                     dvs_q     <= dvs_abs;
                     dvd_q     <= dividend;
                     zero_q    <= (divisor == '0);
                     p_q       <= '0;
                     q_q       <= dvd_abs;
                     cnt_q     <= '0;
                  end
               end
               CAL: begin
                  p_q   <= p_step;
                  q_q   <= q_step;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (state_d == DONE) begin
                     result_q <= {rem_fin, quo_fin};
                     dbz_q    <= zero_q;
                     done_q   <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign op_done     = done_q;
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: signed and unsigned instances share stimulus.
module tb_divider;

   localparam int unsigned WIDTH = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [WIDTH-1:0]  dividend, divisor;
   logic              op_start, op_clear;
   logic              done_s, dbz_s, done_u, dbz_u;
   logic [2*WIDTH-1:0] res_s, res_u;

   int checks   = 0;
   int failures = 0;
   bit run_chk  = 1'b0;

   divider #(.WIDTH(WIDTH), .SIGNED(1'b1)) u_dut_s (
      .clk         (clk),
      .reset_n     (reset_n),
      .dividend    (dividend),
      .divisor     (divisor),
      .op_start    (op_start),
      .op_clear    (op_clear),
      .op_done     (done_s),
      .result      (res_s),
      .div_by_zero (dbz_s)
   );

   divider #(.WIDTH(WIDTH), .SIGNED(1'b0)) u_dut_u (
      .clk         (clk),
      .reset_n     (reset_n),
      .dividend    (dividend),
      .divisor     (divisor),
      .op_start    (op_start),
      .op_clear    (op_clear),
      .op_done     (done_u),
      .result      (res_u),
      .div_by_zero (dbz_u)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference division: returns {div_by_zero, remainder, quotient}.
   function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] d, input bit sgn);
      longint sa, sd, q, r;
      if (d == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
      if (sgn) begin
         sa = longint'($signed(a));
         sd = longint'($signed(d));
      end else begin
         sa = longint'({32'h0, a});
         sd = longint'({32'h0, d});
      end
      q = sa / sd;
      r = sa % sd;
      return {1'b0, r[31:0], q[31:0]};
   endfunction

   // Transaction model: idle / busy with remaining latency / done.
   int          m_phase = 0;
   int          m_left  = 0;
   bit          m_done  = 1'b0;
   logic [64:0] m_s = '0, m_u = '0, pend_s = '0, pend_u = '0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n || op_clear) begin
         m_phase = 0;
         m_done  = 1'b0;
         m_s     = '0;
         m_u     = '0;
      end else if (m_phase == 0 && op_start) begin
         pend_s  = ref_div(dividend, divisor, 1'b1);
         pend_u  = ref_div(dividend, divisor, 1'b0);
         m_left  = WIDTH;
         m_phase = 1;
      end else if (m_phase == 1) begin
         m_left--;
         if (m_left == 0) begin
            m_phase = 2;
            m_done  = 1'b1;
            m_s     = pend_s;
            m_u     = pend_u;
         end
      end
   end

   // Cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (run_chk) begin
         chk("cycle_s", {done_s, dbz_s, res_s}, {m_done, m_s});
         chk("cycle_u", {done_u, dbz_u, res_u}, {m_done, m_u});
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] d,
                         input logic [63:0] exp_s, input logic [63:0] exp_u,
                         input bit lit_s, input bit lit_u);
      int k;
      @(negedge clk);
      dividend = a; divisor = d; op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      dividend = $urandom; divisor = $urandom;
      k = 1;
      while (!done_s && k < 60) begin
         @(negedge clk);
         k++;
      end
      if (!done_s) begin
         chk("done_timeout", 66'(done_s), 66'(1));
      end else begin
         chk("latency", 66'(k - 1), 66'(WIDTH));
         if (lit_s) chk("lit_s", {done_s, dbz_s, res_s}, {1'b1, d == 32'h0, exp_s});
         if (lit_u) chk("lit_u", {done_u, dbz_u, res_u}, {1'b1, d == 32'h0, exp_u});
      end
      op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      op_clear = 1'b1;
      @(negedge clk);
      op_clear = 1'b0;
      chk("clear_s", {done_s, dbz_s, res_s}, '0);
      chk("clear_u", {done_u, dbz_u, res_u}, '0);
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk(name, {done_s, dbz_s, res_s}, '0);
      chk(name, {done_u, dbz_u, res_u}, '0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] a, d;
      int k;
      reset_n  = 1'b0;
      dividend = '0;
      divisor  = '0;
      op_start = 1'b0;
      op_clear = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      run_chk = 1'b1;
      chk("reset_s", {done_s, dbz_s, res_s}, '0);
      chk("reset_u", {done_u, dbz_u, res_u}, '0);

      // Pin the reference model to hand-computed values.
      chk("model_100_7",   66'(ref_div(32'd100, 32'd7, 1'b1)),                 66'(65'h0_00000002_0000000E));
      chk("model_m100_7",  66'(ref_div(32'hFFFFFF9C, 32'd7, 1'b1)),            66'(65'h0_FFFFFFFE_FFFFFFF2));
      chk("model_100_m7",  66'(ref_div(32'd100, 32'hFFFFFFF9, 1'b1)),          66'(65'h0_00000002_FFFFFFF2));
      chk("model_div0",    66'(ref_div(32'd7, 32'd0, 1'b1)),                   66'(65'h1_00000007_FFFFFFFF));
      chk("model_ovf",     66'(ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1)),     66'(65'h0_00000000_80000000));
      chk("model_uns",     66'(ref_div(32'hFFFFFFFF, 32'h10, 1'b0)),           66'(65'h0_0000000F_0FFFFFFF));

      // Directed operations with literal expectations.
      run_op(32'd100,      32'd7,        64'h00000002_0000000E, 64'h00000002_0000000E, 1'b1, 1'b1);
      run_op(32'hFFFFFF9C, 32'd7,        64'hFFFFFFFE_FFFFFFF2, 64'h00000002_24924916, 1'b1, 1'b1);
      run_op(32'd100,      32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 64'h0,                1'b1, 1'b0);
      run_op(32'd7,        32'd0,        64'h00000007_FFFFFFFF, 64'h00000007_FFFFFFFF, 1'b1, 1'b1);
      run_op(32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 64'h80000000_00000000, 1'b1, 1'b1);
      run_op(32'hFFFFFFFF, 32'h10,       64'hFFFFFFFF_00000000, 64'h0000000F_0FFFFFFF, 1'b1, 1'b1);

      // Abort mid-CAL, then restart.
      @(negedge clk);
      dividend = 32'd1000; divisor = 32'd3; op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      repeat (9) begin
         dividend = $urandom; divisor = $urandom;
         @(negedge clk);
      end
      op_clear = 1'b1;
      @(negedge clk);
      op_clear = 1'b0;
      chk("abort_s", {done_s, dbz_s, res_s}, '0);
      run_op(32'd45, 32'd9, 64'h00000000_00000005, 64'h00000000_00000005, 1'b1, 1'b1);

      // Start and clear together in INIT: no operation begins.
      @(negedge clk);
      dividend = 32'd50; divisor = 32'd5; op_start = 1'b1; op_clear = 1'b1;
      @(negedge clk);
      op_start = 1'b0; op_clear = 1'b0;
      repeat (40) @(negedge clk);
      chk("start_clear_idle", 66'(done_s), 66'(0));

      // Reset mid-CAL: outputs drop immediately, no stale done afterwards.
      @(negedge clk);
      dividend = 32'd123456; divisor = 32'd789; op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      repeat (12) @(negedge clk);
      do_reset("reset_mid_cal");
      repeat (40) @(negedge clk);
      chk("no_done_after_reset", 66'(done_s), 66'(0));

      // Reset while holding a result in DONE.
      @(negedge clk);
      dividend = 32'd1234; divisor = 32'd5; op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      k = 1;
      while (!done_s && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk("done_before_reset", {done_s, dbz_s, res_s}, {2'b10, 64'h00000004_000000F6});
      do_reset("reset_in_done");

      // Randomized operations against the model.
      for (int n = 0; n < 150; n++) begin
         a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
         case ($urandom_range(0, 4))
            0:       d = 32'($urandom);
            1:       d = 32'($urandom_range(1, 20));
            2:       d = 32'h0 - 32'($urandom_range(1, 20));
            3:       d = 32'h0;
            default: d = 32'hFFFFFFFF;
         endcase
         run_op(a, d, 64'h0, 64'h0, 1'b0, 1'b0);
      end

      run_chk = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
